// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared state encoding and default constants for player_ctrl
//
// Purpose : one-hot auto-repeat FSM state type and default position/step/repeat
//           constants used as parameter defaults by player_ctrl and btn_repeat.
// Ports   : none (package).
package player_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_DELAY  = 4'b0010,
    ST_REPEAT = 4'b0100,
    ST_LOCK   = 4'b1000
  } rep_state_e;

  localparam int unsigned POS_W_DEF        = 10;
  localparam int unsigned H_MIN_DEF        = 50;
  localparam int unsigned H_MAX_DEF        = 749;
  localparam int unsigned H_START_DEF      = 399;
  localparam int unsigned V_START_DEF      = 475;
  localparam int unsigned STEP_DEF         = 50;
  localparam int unsigned REPEAT_DELAY_DEF = 20;
  localparam int unsigned REPEAT_RATE_DEF  = 8;

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - per-button edge detect and auto-repeat step generator
//
// Purpose : turns one debounced button into step pulses: one on press, one
//           after REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles.
// Ports   : clk_i    clock
//           reset_i  async active-high reset
//           start_i  synchronous re-initialise (held button -> LOCK)
//           btn_i    this direction's button
//           both_i   both buttons high this cycle (conflict -> LOCK)
//           step_o   combinational step request for this cycle
module btn_repeat
  import player_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic btn_i,
  input  logic both_i,
  output logic step_o
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  // Counter starts at 0 in the first held cycle after the step, so the next
  // step falls on the cycle where it reaches period-1.
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  rep_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             armed_q;
  logic             rise;

  // armed_q blocks the first post-reset cycle: a button already held through
  // reset must not look like a fresh press.
  assign rise = btn_i & ~prev_q & armed_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn_i;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_o  = 1'b0;
    if (start_i) begin
      state_d = btn_i ? ST_LOCK : ST_IDLE;
      cnt_d   = '0;
    end else if (both_i) begin
      state_d = ST_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rise) begin
            step_o  = 1'b1;
            state_d = ST_DELAY;
          end else if (btn_i) begin
            // held with no valid edge: wait for a release first
            state_d = ST_LOCK;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!btn_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == ST_DELAY) ? DLY_LAST : RATE_LAST)) begin
            step_o  = 1'b1;
            state_d = ST_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          cnt_d = '0;
          if (!btn_i) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - player position controller with clamped auto-repeat moves
//
// Purpose : holds the player position, applies left/right steps from two
//           btn_repeat instances, clamps to [H_MIN, H_MAX], flags moves/bounds.
// Ports   : clk, reset (async, active high), start (sync new game),
//           btn_left, btn_right -> player_h, player_v, moved, at_left, at_right
module player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned    W            = POS_W_DEF,
  parameter logic [W-1:0]   H_MIN        = W'(H_MIN_DEF),
  parameter logic [W-1:0]   H_MAX        = W'(H_MAX_DEF),
  parameter logic [W-1:0]   H_START      = W'(H_START_DEF),
  parameter logic [W-1:0]   V_START      = W'(V_START_DEF),
  parameter logic [W-1:0]   STEP         = W'(STEP_DEF),
  parameter int unsigned    REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned    REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         btn_left,
  input  logic         btn_right,
  output logic [W-1:0] player_h,
  output logic [W-1:0] player_v,
  output logic         moved,
  output logic         at_left,
  output logic         at_right
);

  logic         both;
  logic         step_l, step_r;
  logic [W-1:0] h_q, h_d;
  logic [W-1:0] v_q;
  logic         moved_q, moved_d;
  logic [W:0]   sum_r;
  logic [W:0]   lim_l;

  assign both = btn_left & btn_right;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .btn_i   (btn_left),
    .both_i  (both),
    .step_o  (step_l)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .btn_i   (btn_right),
    .both_i  (both),
    .step_o  (step_r)
  );

  // One extra bit so the right-step sum and the left threshold never wrap.
  assign sum_r = {1'b0, h_q} + {1'b0, STEP};
  assign lim_l = {1'b0, H_MIN} + {1'b0, STEP};

  always_comb begin
    h_d = h_q;
    if (start) begin
      h_d = H_START;
    end else if (step_r) begin
      h_d = (sum_r > {1'b0, H_MAX}) ? H_MAX : sum_r[W-1:0];
    end else if (step_l) begin
      h_d = ({1'b0, h_q} < lim_l) ? H_MIN : (h_q - STEP);
    end
    // a clamped step that lands on the current value is not a move
    moved_d = ~start & (h_d != h_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q     <= H_START;
      v_q     <= V_START;
      moved_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= V_START;
      moved_q <= moved_d;
    end
  end

  assign player_h = h_q;
  assign player_v = v_q;
  assign moved    = moved_q;
  assign at_left  = (h_q == H_MIN);
  assign at_right = (h_q == H_MAX);

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - directed table-driven bench for player_ctrl
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, btn_left, btn_right;
  logic [9:0] player_h, player_v;
  logic       moved, at_left, at_right;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit st;
    bit bl;
    bit br;
    int h;
    bit mv;
    bit al;
    bit ar;
  } vec_t;

  vec_t vecs[23];
  int   exp_r[8];
  int   exp_l[8];

  player_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .player_h  (player_h),
    .player_v  (player_v),
    .moved     (moved),
    .at_left   (at_left),
    .at_right  (at_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Hold one button for n cycles; steps are expected in cycle 0 and at
  // 20, 28, 36, ... and each moving step advances through the hand table.
  task automatic hold_check(input bit right, input int n, input string nm);
    int  c;
    int  pulses;
    int  cyc;
    bit  st;
    bit  em;
    c = 0;
    pulses = 0;
    if (right) btn_right = 1'b1; else btn_left = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      cyc = k - 1;
      st  = (cyc == 0) || (cyc >= 20 && ((cyc - 20) % 8) == 0);
      em  = 1'b0;
      if (st && c < 7) begin
        c++;
        em = 1'b1;
      end
      check({nm, "_h"}, player_h, right ? exp_r[c] : exp_l[c]);
      check({nm, "_moved"}, moved, em);
      if (moved) pulses++;
    end
    check({nm, "_pulses"}, pulses, 7);
    check({nm, "_at_r"}, at_right, right);
    check({nm, "_at_l"}, at_left, !right);
    btn_right = 1'b0;
    btn_left  = 1'b0;
    tick();
  endtask

  initial begin
    exp_r = '{399, 449, 499, 549, 599, 649, 699, 749};
    exp_l = '{399, 349, 299, 249, 199, 149, 99, 50};

    //          st bl br  h    mv al ar
    vecs[0]  = '{0, 0, 0, 399, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 449, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 449, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 449, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 399, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 399, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 399, 0, 0, 0};
    vecs[7]  = '{0, 1, 1, 399, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 399, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 399, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 349, 1, 0, 0};
    vecs[11] = '{0, 1, 1, 349, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 349, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 399, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 399, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 449, 1, 0, 0};
    vecs[16] = '{1, 0, 1, 399, 0, 0, 0};
    vecs[17] = '{0, 0, 1, 399, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 399, 0, 0, 0};
    vecs[19] = '{0, 0, 1, 449, 1, 0, 0};
    vecs[20] = '{0, 0, 0, 449, 0, 0, 0};
    vecs[21] = '{1, 0, 0, 399, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 399, 0, 0, 0};

    // reset state, checked while reset is still asserted
    reset = 1'b1; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    #3;
    check("rst_h", player_h, 399);
    check("rst_v", player_v, 475);
    check("rst_moved", moved, 0);
    check("rst_at_l", at_left, 0);
    check("rst_at_r", at_right, 0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 23; i++) begin
      start     = vecs[i].st;
      btn_left  = vecs[i].bl;
      btn_right = vecs[i].br;
      tick();
      check($sformatf("vec%0d_h", i), player_h, vecs[i].h);
      check($sformatf("vec%0d_moved", i), moved, vecs[i].mv);
      check($sformatf("vec%0d_at_l", i), at_left, vecs[i].al);
      check($sformatf("vec%0d_at_r", i), at_right, vecs[i].ar);
    end
    start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

    // long holds to both bounds
    do_reset();
    hold_check(1'b1, 100, "hold_r");
    do_reset();
    hold_check(1'b0, 100, "hold_l");
    check("v_const", player_v, 475);

    // start while right is auto-repeating at 599
    do_reset();
    btn_right = 1'b1;
    for (int k = 0; k < 37; k++) tick();
    check("rep_599", player_h, 599);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_h", player_h, 399);
    check("start_moved", moved, 0);
    for (int k = 0; k < 40; k++) tick();
    check("start_hold_h", player_h, 399);
    btn_right = 1'b0;
    tick();
    btn_right = 1'b1;
    tick();
    check("start_repress_h", player_h, 449);
    check("start_repress_moved", moved, 1);
    btn_right = 1'b0;
    tick();

    // async reset in the middle of a hold; held button must not re-trigger
    do_reset();
    btn_right = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    check("pre_rst_h", player_h, 499);
    reset = 1'b1;
    #2;
    check("async_rst_h", player_h, 399);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    check("rst_hold_h", player_h, 399);
    check("rst_hold_moved", moved, 0);
    btn_right = 1'b0;
    tick();
    btn_right = 1'b1;
    tick();
    check("rst_repress_h", player_h, 449);
    btn_right = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
